// File: rtl/gemm_pe_os.sv
// gemm_pe_os -- output-stationary GEMM processing element.
//
// Forwards A east and B south through one register stage each, unconditionally.
// Multiply-accumulates matching A/B beats into a private accumulator. On the
// final K beat of a tile, the finished dot product moves into a result register.
// The accumulator can then start the next tile while the result drains through
// a column-wide load/shift chain.
//
// Ports
//   clk, reset                   clock, async active-high reset
//   a_in/a_valid_in/a_last_in    west operand stream (last = final K element)
//   b_in/b_valid_in              north operand stream
//   a_out/a_valid_out/a_last_out registered copies to east neighbour
//   b_out/b_valid_out            registered copies to south neighbour
//   drain_load, drain_shift      column-wide drain controls (load wins)
//   c_in/c_valid_in              drain word from north neighbour
//   c_out/c_valid_out            drain register
//   res_valid                    result register holds an unloaded result
//   ovf, err                     sticky flags, cleared by err_clr
module gemm_pe_os #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  input  logic                  a_last_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_valid_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  output logic                  a_last_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_valid_out,
  input  logic                  drain_load,
  input  logic                  drain_shift,
  input  logic [ACC_WIDTH-1:0]  c_in,
  input  logic                  c_valid_in,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_valid_out,
  output logic                  res_valid,
  output logic                  ovf,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q, res_q, c_q;
  logic                   res_valid_q, c_valid_q, ovf_q, err_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q;
  logic                   a_valid_q, a_last_q, b_valid_q;

  logic                   mac, mism, last, overrun, res_wr;
  logic                   sum_ovf, ovf_set, err_set;
  logic signed [PW-1:0]   a_ext, b_ext, prod_full;
  logic [ACC_WIDTH-1:0]   prod, sum, acc_d;

  assign mac  = a_valid_in && b_valid_in;
  assign mism = a_valid_in ^ b_valid_in;
  assign last = mac && a_last_in;

  // Operands are widened before the multiply so the full signed product fits.
  assign a_ext     = PW'($signed(a_in));
  assign b_ext     = PW'($signed(b_in));
  assign prod_full = a_ext * b_ext;
  assign prod      = ACC_WIDTH'(prod_full);

  assign sum     = acc_q + prod;
  // Signed overflow: same-sign addends, result sign differs.
  assign sum_ovf = (acc_q[ACC_WIDTH-1] == prod[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  // First beat of a tile loads the product; later beats add (with clamp/wrap).
  always_comb begin
    acc_d   = prod;
    ovf_set = 1'b0;
    if (state_q == ACC) begin
      acc_d = sum;
      if (sum_ovf) begin
        ovf_set = mac;
        if (SATURATE) acc_d = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
    end
  end

  // A pending result that is being loaded this cycle frees the slot, so a
  // simultaneous last beat is not an overrun.
  assign overrun = last && res_valid_q && !drain_load;
  assign res_wr  = last && !overrun;
  assign err_set = mism || overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      c_q         <= '0;
      c_valid_q   <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      a_q         <= '0;
      a_valid_q   <= 1'b0;
      a_last_q    <= 1'b0;
      b_q         <= '0;
      b_valid_q   <= 1'b0;
    end else begin
      a_q       <= a_in;
      a_valid_q <= a_valid_in;
      a_last_q  <= a_last_in;
      b_q       <= b_in;
      b_valid_q <= b_valid_in;

      if (mac) begin
        acc_q   <= acc_d;
        state_q <= a_last_in ? IDLE : ACC;
      end

      if (res_wr) res_q <= acc_d;

      if (drain_load) begin
        c_q       <= res_q;
        c_valid_q <= res_valid_q;
      end else if (drain_shift) begin
        c_q       <= c_in;
        c_valid_q <= c_valid_in;
      end

      if (res_wr)          res_valid_q <= 1'b1;
      else if (drain_load) res_valid_q <= 1'b0;

      // Set events win over a same-cycle clear.
      ovf_q <= ovf_set | (ovf_q & ~err_clr);
      err_q <= err_set | (err_q & ~err_clr);
    end
  end

  assign a_out       = a_q;
  assign a_valid_out = a_valid_q;
  assign a_last_out  = a_last_q;
  assign b_out       = b_q;
  assign b_valid_out = b_valid_q;
  assign c_out       = c_q;
  assign c_valid_out = c_valid_q;
  assign res_valid   = res_valid_q;
  assign ovf         = ovf_q;
  assign err         = err_q;

endmodule

// File: tb/tb_gemm_pe_os.sv
// Bench: a 3-PE drain column (32-bit, saturating) plus two 16-bit PEs
// (saturating / wrapping) sharing the bottom row's operands. All five are
// compared every cycle against an integer-arithmetic tile model, with directed
// value checks layered on top.
module tb_gemm_pe_os;
  localparam int NP = 3;
  localparam int NM = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  a [NP];
  logic [7:0]  b [NP];
  logic        av [NP], al [NP], bv [NP];
  logic        dl, ds, ec;
  logic [31:0] cin_top;
  logic        cvin_top;

  logic [7:0]  ao [NP], bo [NP];
  logic        avo [NP], alo [NP], bvo [NP];
  logic [31:0] co [NP], cin_w [NP];
  logic        cvo [NP], cvin_w [NP], rv [NP], ov [NP], er [NP];

  logic [7:0]  xao [2], xbo [2];
  logic        xavo [2], xalo [2], xbvo [2];
  logic [15:0] xco [2];
  logic        xcvo [2], xrv [2], xov [2], xer [2];

  for (genvar g = 0; g < NP; g++) begin : g_col
    if (g == 0) begin : g_top
      assign cin_w[g]  = cin_top;
      assign cvin_w[g] = cvin_top;
    end else begin : g_mid
      assign cin_w[g]  = co[g-1];
      assign cvin_w[g] = cvo[g-1];
    end
    gemm_pe_os #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1'b1)) u_pe (
      .clk(clk), .reset(reset),
      .a_in(a[g]), .a_valid_in(av[g]), .a_last_in(al[g]),
      .b_in(b[g]), .b_valid_in(bv[g]),
      .a_out(ao[g]), .a_valid_out(avo[g]), .a_last_out(alo[g]),
      .b_out(bo[g]), .b_valid_out(bvo[g]),
      .drain_load(dl), .drain_shift(ds),
      .c_in(cin_w[g]), .c_valid_in(cvin_w[g]),
      .c_out(co[g]), .c_valid_out(cvo[g]),
      .res_valid(rv[g]), .ovf(ov[g]), .err(er[g]), .err_clr(ec));
  end

  for (genvar j = 0; j < 2; j++) begin : g_narrow
    gemm_pe_os #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(j == 0)) u_pe (
      .clk(clk), .reset(reset),
      .a_in(a[2]), .a_valid_in(av[2]), .a_last_in(al[2]),
      .b_in(b[2]), .b_valid_in(bv[2]),
      .a_out(xao[j]), .a_valid_out(xavo[j]), .a_last_out(xalo[j]),
      .b_out(xbo[j]), .b_valid_out(xbvo[j]),
      .drain_load(dl), .drain_shift(ds),
      .c_in(16'd0), .c_valid_in(1'b0),
      .c_out(xco[j]), .c_valid_out(xcvo[j]),
      .res_valid(xrv[j]), .ovf(xov[j]), .err(xer[j]), .err_clr(ec));
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Tile-level model: instances 0..2 = column (32b sat), 3 = 16b sat, 4 = 16b wrap.
  longint m_acc [NM], m_res [NM], m_c [NM], m_fa [NM], m_fb [NM];
  bit     m_busy [NM], m_rv [NM], m_cv [NM], m_ovf [NM], m_err [NM];
  bit     m_fav [NM], m_fal [NM], m_fbv [NM];

  function automatic longint wrapw(input longint x, input int w);
    longint m, r;
    m = longint'(1) <<< w;
    r = x % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NM; k++) begin
      m_acc[k] = 0; m_res[k] = 0; m_c[k] = 0; m_fa[k] = 0; m_fb[k] = 0;
      m_busy[k] = 0; m_rv[k] = 0; m_cv[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
      m_fav[k] = 0; m_fal[k] = 0; m_fbv[k] = 0;
    end
  endtask

  // Descending order so each PE sees its north neighbour's pre-edge drain word.
  task automatic model_step();
    for (int k = NM - 1; k >= 0; k--) begin
      int r, w;
      bit mac, lst, wr, so, se, cvi;
      longint p, nv, full, mx, mn, cin;
      r   = (k < 3) ? k : 2;
      w   = (k < 3) ? 32 : 16;
      mac = av[r] && bv[r];
      lst = mac && al[r];
      p   = longint'($signed(a[r])) * longint'($signed(b[r]));
      mx  = (longint'(1) <<< (w - 1)) - 1;
      mn  = -(longint'(1) <<< (w - 1));
      so  = 0; wr = 0; se = (av[r] != bv[r]); nv = p;
      if (mac && m_busy[k]) begin
        full = m_acc[k] + p;
        if (full > mx || full < mn) begin
          so = 1;
          nv = (k == 4) ? wrapw(full, w) : ((full > mx) ? mx : mn);
        end else nv = full;
      end
      if (k == 0)     begin cin = longint'($signed(cin_top)); cvi = cvin_top; end
      else if (k < 3) begin cin = m_c[k-1]; cvi = m_cv[k-1]; end
      else            begin cin = 0; cvi = 0; end
      if (dl)      begin m_c[k] = m_res[k]; m_cv[k] = m_rv[k]; end
      else if (ds) begin m_c[k] = cin;      m_cv[k] = cvi;     end
      if (mac) begin
        m_acc[k]  = nv;
        m_busy[k] = !al[r];
      end
      if (lst) begin
        if (m_rv[k] && !dl) se = 1;
        else wr = 1;
      end
      if (wr) begin m_res[k] = nv; m_rv[k] = 1; end
      else if (dl) m_rv[k] = 0;
      m_ovf[k] = so || (m_ovf[k] && !ec);
      m_err[k] = se || (m_err[k] && !ec);
      m_fa[k] = longint'(a[r]); m_fb[k] = longint'(b[r]);
      m_fav[k] = av[r]; m_fal[k] = al[r]; m_fbv[k] = bv[r];
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NM; k++) begin
      longint gc, gfa, gfb;
      bit gcv, grv, gov, ger, gfav, gfal, gfbv;
      if (k < 3) begin
        gc = longint'($signed(co[k])); gcv = cvo[k]; grv = rv[k]; gov = ov[k]; ger = er[k];
        gfa = longint'(ao[k]); gfb = longint'(bo[k]); gfav = avo[k]; gfal = alo[k]; gfbv = bvo[k];
      end else begin
        gc = longint'($signed(xco[k-3])); gcv = xcvo[k-3]; grv = xrv[k-3];
        gov = xov[k-3]; ger = xer[k-3];
        gfa = longint'(xao[k-3]); gfb = longint'(xbo[k-3]);
        gfav = xavo[k-3]; gfal = xalo[k-3]; gfbv = xbvo[k-3];
      end
      chk($sformatf("c_out%0d", k), gc, m_c[k]);
      chk($sformatf("c_valid%0d", k), longint'(gcv), longint'(m_cv[k]));
      chk($sformatf("res_valid%0d", k), longint'(grv), longint'(m_rv[k]));
      chk($sformatf("ovf%0d", k), longint'(gov), longint'(m_ovf[k]));
      chk($sformatf("err%0d", k), longint'(ger), longint'(m_err[k]));
      chk($sformatf("a_out%0d", k), gfa, m_fa[k]);
      chk($sformatf("b_out%0d", k), gfb, m_fb[k]);
      chk($sformatf("a_valid_out%0d", k), longint'(gfav), longint'(m_fav[k]));
      chk($sformatf("a_last_out%0d", k), longint'(gfal), longint'(m_fal[k]));
      chk($sformatf("b_valid_out%0d", k), longint'(gfbv), longint'(m_fbv[k]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Idle beats carry junk operands so invalid-beat forwarding is exercised.
  task automatic idle();
    for (int r = 0; r < NP; r++) begin
      av[r] = 0; bv[r] = 0; al[r] = 0;
      a[r] = 8'($urandom); b[r] = 8'($urandom);
    end
    dl = 0; ds = 0; ec = 0; cin_top = 0; cvin_top = 0;
  endtask

  task automatic beat(input int r, input bit l, input int x, input int y);
    av[r] = 1; bv[r] = 1; al[r] = l;
    a[r] = 8'(x); b[r] = 8'(y);
  endtask

  task automatic mac1(input int r, input bit l, input int x, input int y);
    idle(); beat(r, l, x, y); tick();
  endtask

  initial begin
    reset = 1;
    idle();
    model_reset();
    @(posedge clk); #1;
    check_all();
    chk("rst_c_out", longint'(co[2]), 0);
    chk("rst_res_valid", longint'(rv[2]), 0);
    reset = 0;

    // Basic K=4 dot product.
    mac1(2, 0, 3, -4); mac1(2, 0, -2, 5); mac1(2, 0, 7, 2); mac1(2, 1, 1, 100);
    chk("dot_res_valid", longint'(rv[2]), 1);
    idle(); dl = 1; tick();
    chk("dot_c_out", longint'($signed(co[2])), 92);
    chk("dot_c_valid", longint'(cvo[2]), 1);
    chk("dot_rv_cleared", longint'(rv[2]), 0);

    // Back-to-back tiles, load coinciding with the second tile's last beat.
    mac1(2, 0, 1, 1); mac1(2, 1, 2, 2);
    idle(); beat(2, 1, -128, -128); dl = 1; tick();
    chk("b2b_c_out1", longint'($signed(co[2])), 5);
    chk("b2b_rv_kept", longint'(rv[2]), 1);
    idle(); dl = 1; tick();
    chk("b2b_c_out2", longint'($signed(co[2])), 16384);
    chk("b2b_err", longint'(er[2]), 0);

    // 16-bit saturation vs wrap; 32-bit column PE holds the exact sum.
    mac1(2, 0, -128, -128); mac1(2, 1, -128, -128);
    idle(); dl = 1; tick();
    chk("sat_c_out", longint'($signed(xco[0])), 32767);
    chk("wrap_c_out", longint'($signed(xco[1])), -32768);
    chk("sat_ovf", longint'(xov[0]), 1);
    chk("wrap_ovf", longint'(xov[1]), 1);
    chk("wide_c_out", longint'($signed(co[2])), 32768);
    chk("wide_ovf", longint'(ov[2]), 0);
    idle(); ec = 1; tick();
    chk("ovf_clr", longint'(xov[0]), 0);

    // Overrun: second result discarded, first one kept.
    mac1(2, 1, 2, 3); mac1(2, 1, 4, 4);
    chk("ovr_err", longint'(er[2]), 1);
    idle(); dl = 1; tick();
    chk("ovr_kept", longint'($signed(co[2])), 6);
    idle(); ec = 1; tick();
    chk("ovr_err_clr", longint'(er[2]), 0);
    idle(); av[2] = 1; tick();
    chk("mism_err", longint'(er[2]), 1);
    idle(); ec = 1; av[2] = 1; tick();
    chk("set_beats_clr", longint'(er[2]), 1);
    idle(); ec = 1; tick();
    chk("err_clr2", longint'(er[2]), 0);

    // Drain chain: results 10,20,30 top->bottom.
    idle(); beat(0, 1, 2, 5); beat(1, 1, 4, 5); beat(2, 1, 5, 6); tick();
    idle(); dl = 1; tick();
    chk("chain_w0", longint'($signed(co[2])), 30);
    idle(); ds = 1; tick();
    chk("chain_w1", longint'($signed(co[2])), 20);
    idle(); ds = 1; tick();
    chk("chain_w2", longint'($signed(co[2])), 10);
    chk("chain_v2", longint'(cvo[2]), 1);
    mac1(2, 1, 7, 7);
    idle(); dl = 1; ds = 1; cin_top = 32'd12345; cvin_top = 1; tick();
    chk("load_wins", longint'($signed(co[2])), 49);

    // Reset mid-tile with a valid drain word present.
    mac1(2, 0, 9, 9); mac1(2, 0, 3, 3);
    chk("pre_rst_cv", longint'(cvo[2]), 1);
    #2 reset = 1;
    #1;
    model_reset();
    check_all();
    chk("mid_rst_cv", longint'(cvo[2]), 0);
    @(posedge clk); #1;
    reset = 0;
    mac1(2, 1, 5, 6);
    chk("post_rst_rv", longint'(rv[2]), 1);
    idle(); dl = 1; tick();
    chk("post_rst_c_out", longint'($signed(co[2])), 30);

    // Random traffic; second half biases toward long large-operand tiles.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NP; r++) begin
        av[r] = ($urandom_range(0, 3) != 0);
        bv[r] = ($urandom_range(0, 15) == 0) ? !av[r] : av[r];
        if (i < 200) begin
          al[r] = ($urandom_range(0, 3) == 0);
          a[r] = 8'($urandom); b[r] = 8'($urandom);
        end else begin
          al[r] = ($urandom_range(0, 15) == 0);
          a[r] = 8'($urandom_range(96, 127));
          b[r] = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(96, 127))
                                            : 8'(-int'($urandom_range(96, 128)));
        end
      end
      dl = ($urandom_range(0, 4) == 0);
      ds = ($urandom_range(0, 2) == 0);
      ec = ($urandom_range(0, 9) == 0);
      cin_top = $urandom;
      cvin_top = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gemm_pe_os.md
# gemm_pe_os

Output-stationary processing element for the GEMM systolic array, parametrised in operand and accumulator width, with optional saturation.
- Each cycle it forwards A east and B south, one register stage each.
- It multiply-accumulates matching A/B pairs.
- When the final K element arrives, it captures the finished dot product into a result register.
- A column-wide load/shift drain chain moves results out.

The result register is separate from the accumulator, so the next tile can accumulate while the previous result drains.

## Interface
- DATA_WIDTH, 8: signed A/B operand width.
- ACC_WIDTH, 32: signed accumulator/result width; must be ≥ 2*DATA_WIDTH.
- SATURATE, 1: 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- a_in  in  DATA_WIDTH  signed operand from west.
- a_valid_in  in  1  a_in valid.
- a_last_in  in  1  marks final K element of a tile; qualified by a_valid_in.
- b_in  in  DATA_WIDTH  signed operand from north.
- b_valid_in  in  1  b_in valid.
- a_out, a_valid_out, a_last_out  out  DATA_WIDTH/1/1  registered copies to east.
- b_out, b_valid_out  out  DATA_WIDTH/1  registered copies to south.
- drain_load  in  1  column-wide: copy result register into drain register.
- drain_shift  in  1  column-wide: drain register takes c_in/c_valid_in.
- c_in  in  ACC_WIDTH  drain data from north neighbour.
- c_valid_in  in  1  drain valid from north neighbour.
- c_out  out  ACC_WIDTH  drain register.
- c_valid_out  out  1  drain register valid.
- res_valid  out  1  result register holds an unloaded result.
- ovf  out  1  sticky: accumulator overflow occurred.
- err  out  1  sticky: a_valid_in≠b_valid_in, or overrun.
- err_clr  in  1  synchronous clear of ovf and err.

## Operation
- A MAC fires in a cycle where a_valid_in && b_valid_in.
  - product = a_in*b_in, signed, 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
- Accumulator FSM:
  - IDLE: a MAC loads acc ← product (no add) → ACC. If a_last_in is also set, the result is produced directly and the FSM stays IDLE.
  - ACC: a MAC does acc ← acc+product. With a_last_in, result_reg ← acc+product, res_valid←1, FSM → IDLE.
  - K=1 tiles are legal: first and last MAC in the same cycle.
- Overflow is detected when both addends have the same sign and the sum has a different sign.
  - SATURATE=1: clamp to +2^(ACC_WIDTH-1)-1 or −2^(ACC_WIDTH-1).
  - SATURATE=0: wrap.
  - Either mode sets ovf.
- Overrun: a last-MAC while res_valid=1 and drain_load=0.
  - The new result is discarded, result_reg is unchanged, err←1.
  - FSM still → IDLE.
- A mismatched valid (exactly one of a_valid_in/b_valid_in high): no MAC; err←1. Operands still forward.
- Forwarding: a_out/b_out/valids/a_last_out register their inputs every cycle, unconditionally, including invalid beats.
- Drain:
  - drain_load: c_out←result_reg, c_valid_out←res_valid, res_valid←0.
  - Else drain_shift: c_out←c_in, c_valid_out←c_valid_in.
  - Else hold.
  - drain_load has priority over drain_shift.
- err_clr clears ovf/err. A set event in the same cycle wins, so the flag stays 1.

## Timing
- Reset values: all outputs 0, acc 0, result_reg 0, FSM IDLE.
- Reset mid-tile discards the partial sum and any pending result.
- Forward latency: 1 cycle, a_in at edge t → a_out after edge t.
- Result latency: a last-MAC sampled at edge t gives res_valid=1 after edge t. drain_load at edge t+1 at the earliest gives c_valid_out=1 after it.
- Simultaneous last-MAC and drain_load with res_valid=1: the old result goes to c_out, the new result goes to result_reg, res_valid stays 1, no overrun.
- Simultaneous MAC and any drain activity: independent, no stall.
- No backpressure anywhere. A column of N PEs drains in 1 load + N−1 shifts. The bottom PE's c_out is the first word out.
- A new tile may begin on the cycle after a last-MAC: back-to-back tiles have zero bubble.

## Test plan
- Basic dot product, DATA_WIDTH=8, K=4: A=(3,−2,7,1), B=(−4,5,2,100) → res_valid one cycle after last beat; drain_load → c_out=−12−10+14+100=92, c_valid_out=1.
- Back-to-back tiles: tile1 K=2 (1·1,2·2)=5, tile2 K=1 (−128·−128)=16384 with no gap; drain_load on tile2's last cycle → c_out=5, then a second load → 16384; err=0.
- Saturation, ACC_WIDTH=16, SATURATE=1, K=2 of (−128·−128) → result 32767, ovf=1. Same with SATURATE=0 → −32768, ovf=1.
- Overrun: complete two tiles without drain_load → result_reg keeps tile1 value, err=1. err_clr → err=0.
- Drain chain, 3-PE column with results 10,20,30 (top→bottom): load, shift, shift → bottom c_out sequence 30,20,10. Load+shift in the same cycle → load wins.
- Reset mid-tile after 2 MACs and with c_valid_out=1 → all outputs 0. A new tile K=1 (5·6) → 30.
